tv80_alu16_seq: RTL

- Sequencer that performs 16-bit ADD/ADC/SBC/SUB by driving the shared 8-bit TV80 ALU twice: low byte, then high byte.
- Chains carry and flags between the two passes, controls the Arith16/Z16 qualifiers, and returns a 16-bit result plus the final F register.
- Sits between the microcode/execute stage and the ALU; owns the ALU's operand and control inputs while busy.

---
 rtl/tv80_alu16_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tv80_alu16_seq.sv
// tv80_alu16_seq: runs a 16-bit ADD/ADC/SBC/SUB as two passes through the
// shared 8-bit TV80 ALU (low byte, then high byte). Carry and the Z16 zero
// qualifier are chained from the low pass into the high pass.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             request pulse, accepted in IDLE or DONE
//   op                00=ADD16 01=ADC16 10=SBC16 11=SUB16
//   opa, opb, f_in    operands and flags, latched on acceptance
//   busy, done        busy from acceptance through done; done is a 1-cycle pulse
//   result, f_out     16-bit result and final flags, held until the next done
//   alu_*             drive to / response from the shared 8-bit ALU
module tv80_alu16_seq #(
  parameter int unsigned Flag_C = 0,
  parameter int unsigned Flag_Z = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic        alu_arith16,
  output logic        alu_z16,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f_in,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] OP_ADD16 = 2'b00;
  localparam logic [1:0] OP_ADC16 = 2'b01;
  localparam logic [1:0] OP_SBC16 = 2'b10;
  localparam logic [1:0] OP_SUB16 = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;

  // The flag indices must name distinct bits of the 8-bit F register.
  if (Flag_C >= BYTE_W || Flag_Z >= BYTE_W || Flag_C == Flag_Z) begin : g_bad_flag_index
    $error("tv80_alu16_seq: invalid Flag_C/Flag_Z index");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   accept_c;

  logic [1:0]        op_r;
  logic [WORD_W-1:0] opa_r;
  logic [WORD_W-1:0] opb_r;
  logic [BYTE_W-1:0] fin_r;
  logic [BYTE_W-1:0] q_lo;
  logic [BYTE_W-1:0] f_lo;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and ALU drive, decoded from state and the latched op.
  always_comb begin
    state_nx    = state;
    accept_c    = 1'b0;
    alu_op      = ALU_ADD;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    alu_busa    = '0;
    alu_busb    = '0;
    alu_f_in    = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = S_LO;
        end
      end

      S_LO: begin
        alu_busa    = opa_r[7:0];
        alu_busb    = opb_r[7:0];
        alu_f_in    = fin_r;
        alu_arith16 = (op_r == OP_ADD16);
        case (op_r)
          OP_ADD16: alu_op = ALU_ADD;
          OP_ADC16: alu_op = ALU_ADC;
          OP_SBC16: alu_op = ALU_SBC;
          OP_SUB16: alu_op = ALU_SUB;
          default:  alu_op = ALU_ADD;
        endcase
        state_nx = S_HI;
      end

      S_HI: begin
        // Low-pass flags feed the high pass so carry/borrow and Z chain across.
        alu_busa    = opa_r[15:8];
        alu_busb    = opb_r[15:8];
        alu_f_in    = f_lo;
        alu_arith16 = (op_r == OP_ADD16);
        alu_z16     = (op_r != OP_ADD16);
        alu_op      = op_r[1] ? ALU_SBC : ALU_ADC;
        state_nx    = S_DONE;
      end

      S_DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = S_LO;
        end else begin
          state_nx = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Operand latch, low-pass capture and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= '0;
      opa_r  <= '0;
      opb_r  <= '0;
      fin_r  <= '0;
      q_lo   <= '0;
      f_lo   <= '0;
      result <= '0;
      f_out  <= '0;
    end else begin
      if (accept_c) begin
        op_r  <= op;
        opa_r <= opa;
        opb_r <= opb;
        fin_r <= f_in;
      end
      if (state == S_LO) begin
        q_lo <= alu_q;
        f_lo <= alu_f_out;
      end
      if (state == S_HI) begin
        result <= {alu_q, q_lo};
        f_out  <= alu_f_out;
      end
    end
  end

endmodule
